// File: rtl/cluster_monitor_pkg.sv
// Shared widths and snapshot handshake encoding for the cluster count monitor.
package cluster_monitor_pkg;

  localparam int SUM_W_DEF = 24;
  localparam int WIN_W_DEF = 16;
  localparam int OVF_W_DEF = 16;
  localparam int CNT_W     = 8;

  typedef enum logic {
    SNAP_EMPTY = 1'b0,
    SNAP_FULL  = 1'b1
  } snap_state_e;

endpackage

// File: rtl/cluster_count_monitor_sat_accum.sv
// Saturating accumulator: clr has priority over inc; nxt_o is the value the
// register would take if this cycle's addend were accepted.
module sat_accum #(
  parameter int W    = 8,
  parameter int IN_W = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            inc_i,
  input  logic [IN_W-1:0] add_i,
  output logic [W-1:0]    nxt_o
);

  logic [W-1:0] acc_q, acc_d;

  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [IN_W-1:0] b);
    logic [W:0] wide;
    wide = {1'b0, a} + {{(W + 1 - IN_W){1'b0}}, b};
    return wide[W] ? {W{1'b1}} : wide[W-1:0];
  endfunction

  assign nxt_o = sat_add(acc_q, add_i);

  // Next-state: restart on clr, otherwise take the saturated sum when enabled.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (inc_i) begin
      acc_d = nxt_o;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk_i) begin
    if (rst_i) acc_q <= '0;
    else       acc_q <= acc_d;
  end

endmodule

// File: rtl/cluster_count_monitor.sv
// Windowed cluster statistics with a valid/ack snapshot port and an
// overflow-burst detector. Single clock domain (clock4x).
module cluster_count_monitor
  import cluster_monitor_pkg::*;
#(
  parameter int SUM_W = SUM_W_DEF,
  parameter int WIN_W = WIN_W_DEF,
  parameter int OVF_W = OVF_W_DEF
) (
  input  logic             clock4x,
  input  logic             reset,
  input  logic [7:0]       cnt,
  input  logic             overflow,
  input  logic             cnt_valid,
  input  logic             clear,
  input  logic [WIN_W-1:0] win_len,
  input  logic [7:0]       burst_thresh,
  output logic [SUM_W-1:0] snap_sum,
  output logic [7:0]       snap_max,
  output logic [OVF_W-1:0] snap_ovf,
  output logic             snap_valid,
  input  logic             snap_ack,
  output logic             snap_lost,
  output logic             burst
);

  localparam logic [WIN_W-1:0] ONE = {{(WIN_W - 1){1'b0}}, 1'b1};

  snap_state_e      state_q, state_d;
  logic [WIN_W-1:0] len_q, len_d, bx_cnt_q, bx_cnt_d, len_sel;
  logic [7:0]       max_q, max_d, max_nxt, run_nxt, run_new;
  logic [SUM_W-1:0] sum_nxt, snap_sum_q, snap_sum_d;
  logic [OVF_W-1:0] ovf_nxt, snap_ovf_q, snap_ovf_d;
  logic [7:0]       snap_max_q, snap_max_d;
  logic             lost_q, lost_d, burst_q, burst_d;
  logic             sample, win_end, acc_clr;

  // A strobe coinciding with clear is discarded; the window closes on its last sample.
  assign sample  = cnt_valid & ~clear;
  assign win_end = sample & (bx_cnt_q == len_q - ONE);
  assign acc_clr = clear | win_end;
  assign len_sel = (win_len == '0) ? ONE : win_len;
  assign max_nxt = (cnt > max_q) ? cnt : max_q;
  assign run_new = overflow ? run_nxt : 8'd0;

  sat_accum #(.W(SUM_W), .IN_W(8)) u_sum (
    .clk_i(clock4x), .rst_i(reset), .clr_i(acc_clr), .inc_i(sample),
    .add_i(cnt), .nxt_o(sum_nxt)
  );

  sat_accum #(.W(OVF_W), .IN_W(1)) u_ovf (
    .clk_i(clock4x), .rst_i(reset), .clr_i(acc_clr), .inc_i(sample),
    .add_i(overflow), .nxt_o(ovf_nxt)
  );

  // Run length of consecutive overflow samples; a clean sample restarts it.
  sat_accum #(.W(8), .IN_W(1)) u_run (
    .clk_i(clock4x), .rst_i(reset), .clr_i(clear | (sample & ~overflow)),
    .inc_i(sample & overflow), .add_i(1'b1), .nxt_o(run_nxt)
  );

  // Window counter, peak tracker, burst compare and snapshot capture.
  always_comb begin
    bx_cnt_d   = bx_cnt_q;
    len_d      = len_q;
    max_d      = max_q;
    burst_d    = burst_q;
    snap_sum_d = snap_sum_q;
    snap_max_d = snap_max_q;
    snap_ovf_d = snap_ovf_q;
    if (acc_clr) begin
      bx_cnt_d = '0;
      max_d    = '0;
      len_d    = len_sel;
    end else if (sample) begin
      bx_cnt_d = bx_cnt_q + ONE;
      max_d    = max_nxt;
    end
    if (clear) begin
      burst_d = 1'b0;
    end else if (sample) begin
      burst_d = (burst_thresh != 8'd0) && (run_new >= burst_thresh);
    end
    if (win_end) begin
      snap_sum_d = sum_nxt;
      snap_max_d = max_nxt;
      snap_ovf_d = ovf_nxt;
    end
  end

  // Handshake next-state; a load always wins over a pending ack.
  always_comb begin
    state_d = state_q;
    lost_d  = lost_q;
    case (state_q)
      SNAP_EMPTY: if (win_end) state_d = SNAP_FULL;
      SNAP_FULL: begin
        if (win_end) begin
          state_d = SNAP_FULL;
          if (!snap_ack) lost_d = 1'b1;
        end else if (snap_ack) begin
          state_d = SNAP_EMPTY;
        end
      end
      default: state_d = SNAP_EMPTY;
    endcase
    if (clear) lost_d = 1'b0;
  end

  // State and data registers.
  always_ff @(posedge clock4x) begin
    if (reset) begin
      state_q    <= SNAP_EMPTY;
      len_q      <= ONE;
      bx_cnt_q   <= '0;
      max_q      <= '0;
      burst_q    <= 1'b0;
      lost_q     <= 1'b0;
      snap_sum_q <= '0;
      snap_max_q <= '0;
      snap_ovf_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      bx_cnt_q   <= bx_cnt_d;
      max_q      <= max_d;
      burst_q    <= burst_d;
      lost_q     <= lost_d;
      snap_sum_q <= snap_sum_d;
      snap_max_q <= snap_max_d;
      snap_ovf_q <= snap_ovf_d;
    end
  end

  assign snap_valid = (state_q == SNAP_FULL);
  assign snap_sum   = snap_sum_q;
  assign snap_max   = snap_max_q;
  assign snap_ovf   = snap_ovf_q;
  assign snap_lost  = lost_q;
  assign burst      = burst_q;

endmodule

// File: tb/tb_cluster_count_monitor.sv
// Table-driven bench for cluster_count_monitor with a scoreboard queue.
// A second instance with an 8-bit sum checks sum saturation.
module tb_cluster_count_monitor;

  logic        clock4x = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  cnt = '0;
  logic        overflow = 1'b0;
  logic        cnt_valid = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] win_len = 16'd4;
  logic [7:0]  burst_thresh = '0;
  logic        snap_ack = 1'b0;

  logic [23:0] snap_sum;
  logic [7:0]  snap_max;
  logic [15:0] snap_ovf;
  logic        snap_valid, snap_lost, burst;

  logic [7:0]  s8_sum;
  logic [7:0]  s8_max;
  logic [15:0] s8_ovf;
  logic        s8_valid, s8_lost, s8_burst;

  always #5 clock4x = ~clock4x;

  cluster_count_monitor dut (
    .clock4x(clock4x), .reset(reset), .cnt(cnt), .overflow(overflow),
    .cnt_valid(cnt_valid), .clear(clear), .win_len(win_len),
    .burst_thresh(burst_thresh), .snap_sum(snap_sum), .snap_max(snap_max),
    .snap_ovf(snap_ovf), .snap_valid(snap_valid), .snap_ack(snap_ack),
    .snap_lost(snap_lost), .burst(burst)
  );

  cluster_count_monitor #(.SUM_W(8)) dut8 (
    .clock4x(clock4x), .reset(reset), .cnt(cnt), .overflow(overflow),
    .cnt_valid(cnt_valid), .clear(clear), .win_len(win_len),
    .burst_thresh(burst_thresh), .snap_sum(s8_sum), .snap_max(s8_max),
    .snap_ovf(s8_ovf), .snap_valid(s8_valid), .snap_ack(snap_ack),
    .snap_lost(s8_lost), .burst(s8_burst)
  );

  typedef struct {
    string name;
    bit    rst, clr, v;
    int    c;
    bit    o, a;
    int    wl, bt;
    bit    sv;
    int    sum, mx, ov;
    bit    lost, bst;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   passed = 0;
  int   total  = 0;

  function automatic vec_t V(string n, bit rst, bit clr, bit v, int c, bit o, bit a,
                             int wl, int bt, bit sv, int sum, int mx, int ov,
                             bit lost, bit bst);
    vec_t t;
    t.name = n; t.rst = rst; t.clr = clr; t.v = v; t.c = c; t.o = o; t.a = a;
    t.wl = wl; t.bt = bt; t.sv = sv; t.sum = sum; t.mx = mx; t.ov = ov;
    t.lost = lost; t.bst = bst;
    return t;
  endfunction

  task automatic chk(string nm, longint act, longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic apply(vec_t t);
    vec_t e;
    @(negedge clock4x);
    reset = t.rst; clear = t.clr; cnt_valid = t.v; cnt = 8'(t.c);
    overflow = t.o; snap_ack = t.a; win_len = 16'(t.wl); burst_thresh = 8'(t.bt);
    sb.push_back(t);
    @(posedge clock4x);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk({e.name, ".valid"}, snap_valid, e.sv);
      chk({e.name, ".sum"},   snap_sum,   e.sum);
      chk({e.name, ".max"},   snap_max,   e.mx);
      chk({e.name, ".ovf"},   snap_ovf,   e.ov);
      chk({e.name, ".lost"},  snap_lost,  e.lost);
      chk({e.name, ".burst"}, burst,      e.bst);
      chk({e.name, ".sum8"},  s8_sum,     (e.sum > 255) ? 255 : e.sum);
      chk({e.name, ".valid8"}, s8_valid,  e.sv);
      chk({e.name, ".max8"},  s8_max,     e.mx);
      chk({e.name, ".ovf8"},  s8_ovf,     e.ov);
      chk({e.name, ".lost8"}, s8_lost,    e.lost);
      chk({e.name, ".burst8"}, s8_burst,  e.bst);
    end
  endtask

  initial begin
    //           name          rst clr v  c   o  a  wl bt  sv sum  mx  ov lost bst
    tbl.push_back(V("rst0",      1, 0, 0, 0,  0, 0, 4, 0,  0, 0,   0,  0, 0, 0));
    tbl.push_back(V("rst1",      1, 0, 0, 0,  0, 0, 4, 0,  0, 0,   0,  0, 0, 0));
    tbl.push_back(V("clr_w4",    0, 1, 0, 0,  0, 0, 4, 0,  0, 0,   0,  0, 0, 0));
    tbl.push_back(V("w4_s1",     0, 0, 1, 3,  0, 0, 4, 0,  0, 0,   0,  0, 0, 0));
    tbl.push_back(V("w4_s2",     0, 0, 1, 5,  0, 0, 4, 0,  0, 0,   0,  0, 0, 0));
    tbl.push_back(V("w4_s3",     0, 0, 1, 2,  0, 0, 4, 0,  0, 0,   0,  0, 0, 0));
    tbl.push_back(V("w4_s4",     0, 0, 1, 7,  0, 0, 4, 0,  1, 17,  7,  0, 0, 0));
    tbl.push_back(V("ack",       0, 0, 0, 0,  0, 1, 4, 0,  0, 17,  7,  0, 0, 0));
    tbl.push_back(V("ack_empty", 0, 0, 0, 0,  0, 1, 4, 0,  0, 17,  7,  0, 0, 0));
    tbl.push_back(V("clr_w2",    0, 1, 0, 0,  0, 0, 2, 0,  0, 17,  7,  0, 0, 0));
    tbl.push_back(V("w2a_s1",    0, 0, 1, 1,  1, 0, 2, 0,  0, 17,  7,  0, 0, 0));
    tbl.push_back(V("w2a_s2",    0, 0, 1, 4,  1, 0, 2, 0,  1, 5,   4,  2, 0, 0));
    tbl.push_back(V("w2b_s1",    0, 0, 1, 6,  0, 0, 2, 0,  1, 5,   4,  2, 0, 0));
    tbl.push_back(V("w2b_ovw",   0, 0, 1, 2,  1, 0, 2, 0,  1, 8,   6,  1, 1, 0));
    tbl.push_back(V("lost_hold", 0, 0, 0, 0,  0, 0, 2, 0,  1, 8,   6,  1, 1, 0));
    tbl.push_back(V("clr_lost",  0, 1, 0, 0,  0, 0, 2, 0,  1, 8,   6,  1, 0, 0));
    tbl.push_back(V("w2c_s1",    0, 0, 1, 10, 0, 0, 2, 0,  1, 8,   6,  1, 0, 0));
    tbl.push_back(V("w2c_ldack", 0, 0, 1, 20, 0, 1, 2, 0,  1, 30,  20, 0, 0, 0));
    tbl.push_back(V("ack2",      0, 0, 0, 0,  0, 1, 2, 0,  0, 30,  20, 0, 0, 0));
    tbl.push_back(V("clr_bt3",   0, 1, 0, 0,  0, 0, 2, 3,  0, 30,  20, 0, 0, 0));
    tbl.push_back(V("run1",      0, 0, 1, 0,  1, 0, 2, 3,  0, 30,  20, 0, 0, 0));
    tbl.push_back(V("run2",      0, 0, 1, 0,  1, 0, 2, 3,  1, 0,   0,  2, 0, 0));
    tbl.push_back(V("run3",      0, 0, 1, 0,  1, 0, 2, 3,  1, 0,   0,  2, 0, 1));
    tbl.push_back(V("run_hold",  0, 0, 0, 0,  0, 0, 2, 3,  1, 0,   0,  2, 0, 1));
    tbl.push_back(V("run_break", 0, 0, 1, 0,  0, 0, 2, 3,  1, 0,   0,  1, 1, 0));
    tbl.push_back(V("clr_bt0",   0, 1, 0, 0,  0, 0, 2, 0,  1, 0,   0,  1, 0, 0));
    tbl.push_back(V("bt0_s1",    0, 0, 1, 0,  1, 1, 2, 0,  0, 0,   0,  1, 0, 0));
    tbl.push_back(V("bt0_s2",    0, 0, 1, 0,  1, 0, 2, 0,  1, 0,   0,  2, 0, 0));
    tbl.push_back(V("bt0_s3",    0, 0, 1, 0,  1, 0, 2, 0,  1, 0,   0,  2, 0, 0));
    tbl.push_back(V("bt0_ldack", 0, 0, 1, 0,  1, 1, 2, 0,  1, 0,   0,  2, 0, 0));
    tbl.push_back(V("ack3",      0, 0, 0, 0,  0, 1, 2, 0,  0, 0,   0,  2, 0, 0));
    tbl.push_back(V("clr_w0",    0, 1, 0, 0,  0, 0, 0, 0,  0, 0,   0,  2, 0, 0));
    tbl.push_back(V("w0_s1",     0, 0, 1, 9,  0, 0, 0, 0,  1, 9,   9,  0, 0, 0));
    tbl.push_back(V("ack4",      0, 0, 0, 0,  0, 1, 0, 0,  0, 9,   9,  0, 0, 0));
    tbl.push_back(V("clr_sat",   0, 1, 0, 0,  0, 0, 2, 0,  0, 9,   9,  0, 0, 0));
    tbl.push_back(V("sat_s1",    0, 0, 1, 200,0, 0, 2, 0,  0, 9,   9,  0, 0, 0));
    tbl.push_back(V("sat_s2",    0, 0, 1, 200,0, 0, 2, 0,  1, 400, 200,0, 0, 0));
    tbl.push_back(V("ack5",      0, 0, 0, 0,  0, 1, 2, 0,  0, 400, 200,0, 0, 0));
    tbl.push_back(V("clr_w4b",   0, 1, 0, 0,  0, 0, 4, 0,  0, 400, 200,0, 0, 0));
    tbl.push_back(V("old_s1",    0, 0, 1, 1,  0, 0, 4, 0,  0, 400, 200,0, 0, 0));
    tbl.push_back(V("old_s2",    0, 0, 1, 1,  0, 0, 4, 0,  0, 400, 200,0, 0, 0));
    tbl.push_back(V("clr_drop",  0, 1, 1, 50, 0, 0, 4, 0,  0, 400, 200,0, 0, 0));
    tbl.push_back(V("fresh_s1",  0, 0, 1, 2,  0, 0, 4, 0,  0, 400, 200,0, 0, 0));
    tbl.push_back(V("fresh_s2",  0, 0, 1, 3,  0, 0, 4, 0,  0, 400, 200,0, 0, 0));
    tbl.push_back(V("fresh_s3",  0, 0, 1, 4,  0, 0, 4, 0,  0, 400, 200,0, 0, 0));
    tbl.push_back(V("fresh_s4",  0, 0, 1, 5,  0, 0, 4, 0,  1, 14,  5,  0, 0, 0));
    tbl.push_back(V("mid_s1",    0, 0, 1, 8,  0, 0, 4, 0,  1, 14,  5,  0, 0, 0));
    tbl.push_back(V("rst_mid",   1, 0, 0, 0,  0, 0, 4, 0,  0, 0,   0,  0, 0, 0));
    tbl.push_back(V("post_rst1", 0, 0, 0, 0,  0, 0, 4, 0,  0, 0,   0,  0, 0, 0));
    tbl.push_back(V("post_rst2", 0, 0, 0, 0,  0, 0, 4, 0,  0, 0,   0,  0, 0, 0));
    tbl.push_back(V("clr_post",  0, 1, 0, 0,  0, 0, 4, 0,  0, 0,   0,  0, 0, 0));
    tbl.push_back(V("post_s1",   0, 0, 1, 1,  0, 0, 4, 0,  0, 0,   0,  0, 0, 0));
    tbl.push_back(V("post_s2",   0, 0, 1, 1,  0, 0, 4, 0,  0, 0,   0,  0, 0, 0));
    tbl.push_back(V("post_s3",   0, 0, 1, 1,  0, 0, 4, 0,  0, 0,   0,  0, 0, 0));
    tbl.push_back(V("post_s4",   0, 0, 1, 1,  0, 0, 4, 0,  1, 4,   1,  0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Snapshot must hold steady while FULL and unacknowledged, then drop on ack.
    for (int k = 0; k < 4; k++)
      apply(V($sformatf("hold%0d", k), 0, 0, 0, 0, 0, 0, 4, 0, 1, 4, 1, 0, 0, 0));
    apply(V("hold_ack", 0, 0, 0, 0, 0, 1, 4, 0, 0, 4, 1, 0, 0, 0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cluster_count_monitor.md
Name: cluster_count_monitor

Overview:
Downstream consumer of the per-BX cluster count and overflow flag produced by the cluster counter. It accumulates windowed statistics: BX-count window, summed clusters, peak count, overflow-BX count and consecutive-overflow burst detection. At each window end it publishes a snapshot through a valid/ack handshake to the slow-control/readout side. Runs entirely in the clock4x domain.

Parameters:
SUM_W, 24, width of windowed cluster sum (saturating)
WIN_W, 16, width of window length and BX counter
OVF_W, 16, width of overflow-BX counter (saturating)

Ports:
clock4x  in  1  sole clock
reset  in  1  synchronous, active-high reset
cnt  in  8  cluster count for the current BX
overflow  in  1  count-exceeds-limit flag for the same BX
cnt_valid  in  1  cnt/overflow qualify this cycle (one strobe per BX)
clear  in  1  synchronous restart of the window and accumulators
win_len  in  WIN_W  BXs per window; 0 treated as 1; sampled at window start
burst_thresh  in  8  consecutive overflow BXs that flag a burst; 0 disables
snap_sum  out  SUM_W  windowed cluster sum
snap_max  out  8  peak cnt in window
snap_ovf  out  OVF_W  overflow BXs in window
snap_valid  out  1  snapshot pending
snap_ack  in  1  consumer accepts snapshot
snap_lost  out  1  sticky: unacked snapshot was overwritten
burst  out  1  consecutive-overflow run >= burst_thresh

Behaviour:
- Reset: all accumulators, BX counter, run length, snapshot registers and every output go to 0. The latched window length goes to 1.
- Reset has priority over clear. Clear has priority over cnt_valid.
- Accumulation, on each cnt_valid:
  - sum += cnt, saturating at all-ones.
  - max = max(max, cnt).
  - ovf += overflow, saturating.
  - bx_cnt += 1.
- Window end: the sample with bx_cnt == len-1 is the last one. On the next cycle (latency 1 from that strobe):
  - the snapshot registers load the totals including that sample;
  - the accumulators and bx_cnt restart at 0;
  - win_len is re-latched (0 becomes 1).
- Window length 1 means every valid sample produces its own snapshot.
- Snapshot handshake FSM, states EMPTY and FULL:
  - EMPTY -> FULL on snapshot load. snap_valid = (state == FULL).
  - FULL with snap_ack and no load -> EMPTY.
  - FULL with load and snap_ack in the same cycle -> stays FULL with new data; snap_lost is not set.
  - FULL with load and no snap_ack -> data is overwritten and snap_lost is set.
  - snap_ack while EMPTY is ignored.
  - snap_lost clears only on reset or clear.
- Snapshot outputs hold stable while FULL, except on an overwrite.
- Burst detection:
  - run increments on cnt_valid with overflow=1 and saturates at 255.
  - run returns to 0 on cnt_valid with overflow=0.
  - burst is registered: burst = (burst_thresh != 0) && (run >= burst_thresh), one cycle after the qualifying sample.
  - Cycles without cnt_valid leave run and burst unchanged.
- Clear:
  - zeroes accumulators, bx_cnt, run, burst and snap_lost;
  - re-latches win_len;
  - discards any cnt_valid in the same cycle;
  - leaves the snapshot registers and FSM state untouched.
- Reset mid-window discards the partial window and gives no snapshot.

Decomposition:
- Shared package cluster_monitor_pkg: SUM_W/WIN_W/OVF_W defaults, snapshot state encoding (EMPTY=0, FULL=1).
- One sub-module, sat_accum: saturating adder with width parameter, inputs add/inc and clr, used for sum, ovf and run.
- The top level contains the window counter, max tracker, handshake FSM and burst compare.

Test Plan:
- win_len=4, cnt=3,5,2,7 on consecutive strobes, no ack -> cycle after 4th strobe: snap_valid=1, sum=17, max=7, ovf=0; accumulators restart.
- win_len=2, overflow=1 on strobes 1 and 2, ack withheld through the next window -> second load overwrites: snap_lost=1, snap_valid stays 1. Ack the same cycle as a load -> snap_lost stays 0.
- burst_thresh=3, overflow pattern 1,1,1,0 -> burst=1 one cycle after the 3rd strobe, burst=0 one cycle after the 4th. With burst_thresh=0 -> burst never asserts.
- win_len=0, cnt=9 single strobe -> snapshot after one sample: sum=9, max=9.
- Sum saturation with SUM_W=8 override: 2 strobes of cnt=200 in a window of 2 -> snap_sum=255.
- clear asserted with cnt_valid mid-window (2 of 4 samples taken) -> sample dropped, next snapshot requires 4 fresh strobes. Reset mid-window -> all outputs 0, no snapshot.
